// File: rtl/lms_pkg.sv
// Shared helpers for the LMS datapath: width math, saturating add and the
// accumulator state encoding.
package lms_pkg;

  typedef enum logic {
    FIRST,
    ACCUM
  } acc_state_t;

  typedef struct packed {
    logic              ovf;
    logic signed [63:0] sum;
  } sat_res_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Signed add of two w-bit values carried in 64 bits. The 64-bit sum is
  // exact, so it doubles as the w+1-bit overflow check. On overflow the
  // result is clamped (sat=1) or wrapped to w bits (sat=0); the returned
  // value is always sign-extended from w bits.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w,
                                       input logic               sat);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    s     = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = (s > hi) || (s < lo);
    if (!r.ovf)
      r.sum = s;
    else if (sat)
      r.sum = (s > hi) ? hi : lo;
    else
      r.sum = (s <<< (64 - w)) >>> (64 - w);
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: pairs N signed W-bit inputs into
// ceil(N/2) W+1-bit sums. An odd last input passes through sign-extended.
module adder_tree_level #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_valid,
  input  logic                           d_last,
  input  logic [N*W-1:0]                 d,
  output logic                           q_valid,
  output logic                           q_last,
  output logic [((N+1)/2)*(W+1)-1:0]     q
);

  localparam int M = (N + 1) / 2;

  for (genvar j = 0; j < M; j++) begin : g_pair
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W:0]   sum_p;

    assign a = d[2*j*W +: W];
    if (2*j + 1 < N) begin : g_b
      assign b = d[(2*j+1)*W +: W];
    end else begin : g_zero
      assign b = '0;
    end

    // Exact pair sum: one extra bit absorbs the carry.
    always_ff @(posedge clk)
      sum_p <= {a[W-1], a} + {b[W-1], b};

    assign q[j*(W+1) +: W+1] = sum_p;
  end

  // Framing bits follow the data through this level.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end else begin
      q_valid <= d_valid;
      q_last  <= d_last;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed multi-lane adder tree with lane masking and a frame
// accumulator (saturating or wrapping) for the LMS summing stage.
module adder_tree_acc
  import lms_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LANES     = 8,
  parameter int ACC_EXT_W = 4,
  parameter bit SAT       = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      din_valid,
  input  logic                                      din_last,
  input  logic [LANES-1:0]                          lane_mask,
  input  logic [DATA_W*LANES-1:0]                   dataIn,
  output logic                                      sum_valid,
  output logic [DATA_W+clog2(LANES)+ACC_EXT_W-1:0]  sumOut,
  output logic                                      ovf
);

  localparam int D      = clog2(LANES);
  localparam int TREE_W = DATA_W + D;
  localparam int SUM_W  = TREE_W + ACC_EXT_W;
  localparam int LEAVES = 1 << D;

  // Bit offset of tree level k inside the flat level bus.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += (LEAVES >> j) * (DATA_W + j);
    return o;
  endfunction

  localparam int BUS_W = lvl_off(D + 1);

  logic [BUS_W-1:0] tree_bus;
  logic [D:0]       vld_bus;
  logic [D:0]       last_bus;
  logic             vld_p0;
  logic             last_p0;

  // ---- stage p0: input register with lane masking, padded to 2^D leaves
  for (genvar i = 0; i < LEAVES; i++) begin : g_lane
    if (i < LANES) begin : g_live
      logic [DATA_W-1:0] lane_p0;
      // Cleared lanes enter the tree as zero.
      always_ff @(posedge clk)
        lane_p0 <= lane_mask[i] ? dataIn[i*DATA_W +: DATA_W] : '0;
      assign tree_bus[i*DATA_W +: DATA_W] = lane_p0;
    end else begin : g_pad
      assign tree_bus[i*DATA_W +: DATA_W] = '0;
    end
  end

  // Input framing register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= din_valid;
      last_p0 <= din_last;
    end
  end

  assign vld_bus[0]  = vld_p0;
  assign last_bus[0] = last_p0;

  // ---- stages p1..pD: registered tree levels
  for (genvar k = 0; k < D; k++) begin : g_level
    adder_tree_level #(
      .N(LEAVES >> k),
      .W(DATA_W + k)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .d_valid (vld_bus[k]),
      .d_last  (last_bus[k]),
      .d       (tree_bus[lvl_off(k) +: (LEAVES >> k) * (DATA_W + k)]),
      .q_valid (vld_bus[k+1]),
      .q_last  (last_bus[k+1]),
      .q       (tree_bus[lvl_off(k+1) +: (LEAVES >> (k+1)) * (DATA_W + k + 1)])
    );
  end

  logic signed [TREE_W-1:0] tree_sum;
  logic                     tree_vld;
  logic                     tree_last;

  assign tree_sum  = tree_bus[lvl_off(D) +: TREE_W];
  assign tree_vld  = vld_bus[D];
  assign tree_last = last_bus[D];

  // ---- stage pD+1: frame accumulator and output registers
  acc_state_t               state;
  acc_state_t               state_next;
  logic signed [SUM_W-1:0]  acc;
  logic signed [SUM_W-1:0]  acc_next;
  logic                     flag;
  logic                     flag_next;
  logic signed [63:0]       acc_wide;
  logic signed [63:0]       tree_wide;
  sat_res_t                 res;
  logic                     unused_hi;

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FIRST;
    else     state <= state_next;
  end

  // Next accumulator value, frame overflow flag and FSM transition.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    flag_next  = flag;
    acc_wide   = (state == FIRST) ? 64'sd0 : 64'(acc);
    tree_wide  = 64'(tree_sum);
    res        = sat_add(acc_wide, tree_wide, SUM_W, SAT);
    if (tree_vld) begin
      acc_next   = res.sum[SUM_W-1:0];
      flag_next  = ((state == ACCUM) && flag) || res.ovf;
      state_next = tree_last ? FIRST : ACCUM;
    end
  end

  assign unused_hi = ^res.sum[63:SUM_W];

  // Accumulator and frame-result registers; sumOut/ovf hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      flag      <= 1'b0;
      sum_valid <= 1'b0;
      sumOut    <= '0;
      ovf       <= 1'b0;
    end else begin
      acc       <= acc_next;
      flag      <= flag_next;
      sum_valid <= tree_vld && tree_last;
      if (tree_vld && tree_last) begin
        sumOut <= acc_next;
        ovf    <= flag_next;
      end
    end
  end

endmodule
